mac_operand_feeder: RTL and testbench

MAC_OPERAND_FEEDER -- requirements
Module: mac_operand_feeder

---
 rtl/mac_operand_feeder.sv | 113 +++++++++++
 tb/tb_mac_operand_feeder.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mac_operand_feeder.sv
// mac_operand_feeder: collects 6 signed Q4.9 A/B pairs into a double-buffered bank for a 12-input MAC.
// Define FEEDER_CONJ_NEG_EN to store B of odd pairs negated (saturating).
module mac_operand_feeder #(
  parameter int NPAIR = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [12:0] in_a,
  input  logic [12:0] in_b,
  input  logic        in_last,
  output logic [12:0] op1,
  output logic [12:0] op2,
  output logic [12:0] op3,
  output logic [12:0] op4,
  output logic [12:0] op5,
  output logic [12:0] op6,
  output logic [12:0] op7,
  output logic [12:0] op8,
  output logic [12:0] op9,
  output logic [12:0] op10,
  output logic [12:0] op11,
  output logic [12:0] op12,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        frame_err
);
  typedef enum logic [1:0] {EMPTY, HOLD, FULL} state_t;
  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [12:0] la_q [NPAIR], la_d [NPAIR], lb_q [NPAIR], lb_d [NPAIR];
  logic [12:0] ha_q [NPAIR], ha_d [NPAIR], hb_q [NPAIR], hb_d [NPAIR];
  logic        frame_err_q, frame_err_d;
  logic        accept, consume, last_acc, swap;
  logic [12:0] b_st;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= EMPTY;
    else state_q <= state_d;
  // swap copies the load bank (with the pair accepted this edge) into the hold bank
  always_comb begin
    state_d = state_q;
    swap = 1'b0;
    case (state_q)
      EMPTY: if (last_acc) begin state_d = HOLD; swap = 1'b1; end
      HOLD:
        if (last_acc && consume) swap = 1'b1;
        else if (last_acc) state_d = FULL;
        else if (consume) state_d = EMPTY;
      FULL: if (consume) begin state_d = HOLD; swap = 1'b1; end
      default: state_d = EMPTY;
    endcase
  end
  always_comb begin
    in_ready = state_q != FULL;
    out_valid = state_q != EMPTY;
  end
  assign accept = in_valid && in_ready;
  assign consume = out_valid && out_ready;
  assign last_acc = accept && cnt_q == 3'(NPAIR - 1);
  always_comb begin
`ifdef FEEDER_CONJ_NEG_EN
    b_st = !cnt_q[0] ? in_b : in_b == 13'h1000 ? 13'h0fff : 13'd0 - in_b;
`else
    b_st = in_b;
`endif
  end
  always_comb begin
    la_d = la_q;
    lb_d = lb_q;
    ha_d = ha_q;
    hb_d = hb_q;
    cnt_d = !accept ? cnt_q : last_acc ? 3'd0 : cnt_q + 3'd1;
    frame_err_d = frame_err_q || (accept && (in_last != (cnt_q == 3'(NPAIR - 1))));
    if (accept) begin
      la_d[cnt_q] = in_a;
      lb_d[cnt_q] = b_st;
    end
    if (swap) begin
      ha_d = la_d;
      hb_d = lb_d;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      la_q <= '{default: '0};
      lb_q <= '{default: '0};
      ha_q <= '{default: '0};
      hb_q <= '{default: '0};
      frame_err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      la_q <= la_d;
      lb_q <= lb_d;
      ha_q <= ha_d;
      hb_q <= hb_d;
      frame_err_q <= frame_err_d;
    end
  assign frame_err = frame_err_q;
  assign op1 = ha_q[0];
  assign op2 = hb_q[0];
  assign op3 = ha_q[1];
  assign op4 = hb_q[1];
  assign op5 = ha_q[2];
  assign op6 = hb_q[2];
  assign op7 = ha_q[3];
  assign op8 = hb_q[3];
  assign op9 = ha_q[4];
  assign op10 = hb_q[4];
  assign op11 = ha_q[5];
  assign op12 = hb_q[5];
endmodule

// File: tb/tb_mac_operand_feeder.sv
// tb_mac_operand_feeder: directed checks of pair collection, bank swap, backpressure, framing and reset.
module tb_mac_operand_feeder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [12:0] in_a = '0;
  logic [12:0] in_b = '0;
  logic        in_last = 1'b0;
  logic [12:0] op [12];
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        frame_err;
  int          n_pass = 0;
  int          n_tot = 0;

  mac_operand_feeder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .op1(op[0]), .op2(op[1]), .op3(op[2]), .op4(op[3]), .op5(op[4]), .op6(op[5]),
    .op7(op[6]), .op8(op[7]), .op9(op[8]), .op10(op[9]), .op11(op[10]), .op12(op[11]),
    .out_valid(out_valid), .out_ready(out_ready), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tot++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic push(input int a, input int b, input bit last);
    int n = 0;
    in_valid = 1'b1;
    in_a = a[12:0];
    in_b = b[12:0];
    in_last = last;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 50) chk("ready_wait", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_op1", int'($signed(op[0])), 0);
    chk("rst_op12", int'($signed(op[11])), 0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", int'(in_ready), 1);
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      push(k + 1, -(k + 1), k == 5);
      if (k == 4) chk("basic_ov_early", int'(out_valid), 0);
    end
    chk("basic_ov", int'(out_valid), 1);
    chk("basic_op1", int'($signed(op[0])), 1);
    chk("basic_op2", int'($signed(op[1])), -1);
    chk("basic_op11", int'($signed(op[10])), 6);
`ifdef FEEDER_CONJ_NEG_EN
    chk("basic_op12", int'($signed(op[11])), 6);
`else
    chk("basic_op12", int'($signed(op[11])), -6);
`endif
    chk("basic_frame_err", int'(frame_err), 0);
    tick();
    chk("basic_drained", int'(out_valid), 0);
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      push(10 + i, i, (i % 6) == 5);
      if (i == 5) chk("bp_ov_first", int'(out_valid), 1);
      if (i == 10) chk("bp_ready_11", int'(in_ready), 1);
    end
    chk("bp_ready_low", int'(in_ready), 0);
    chk("bp_op1_held", int'($signed(op[0])), 10);
    tick();
    chk("bp_stable_op1", int'($signed(op[0])), 10);
    chk("bp_stable_ov", int'(out_valid), 1);
    out_ready = 1'b1;
    tick();
    chk("bp_second_ov", int'(out_valid), 1);
    chk("bp_second_op1", int'($signed(op[0])), 16);
    chk("bp_second_op9", int'($signed(op[8])), 20);
    chk("bp_ready_back", int'(in_ready), 1);
    tick();
    chk("bp_drained", int'(out_valid), 0);
    out_ready = 1'b0;
    for (int i = 0; i < 11; i++) push(i < 6 ? 30 + i : 34 + i, 0, (i % 6) == 5);
    chk("sim_held_op1", int'($signed(op[0])), 30);
    out_ready = 1'b1;
    push(45, 0, 1'b1);
    chk("sim_ov", int'(out_valid), 1);
    chk("sim_op1", int'($signed(op[0])), 40);
    chk("sim_op11", int'($signed(op[10])), 45);
    chk("sim_ready", int'(in_ready), 1);
    tick();
    chk("sim_drained", int'(out_valid), 0);
    for (int k = 0; k < 6; k++) begin
      push(50 + k, 0, k == 2 || k == 5);
      if (k == 1) chk("fe_clear", int'(frame_err), 0);
      if (k == 2) chk("fe_set", int'(frame_err), 1);
    end
    chk("fe_ov", int'(out_valid), 1);
    chk("fe_op5", int'($signed(op[4])), 52);
    tick();
    chk("fe_sticky", int'(frame_err), 1);
    for (int k = 0; k < 4; k++) push(100 + k, 0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_op1", int'($signed(op[0])), 0);
    chk("mid_rst_frame_err", int'(frame_err), 0);
    chk("mid_rst_ov", int'(out_valid), 0);
    #4 rst_n = 1'b1;
    tick();
    chk("mid_rst_ready", int'(in_ready), 1);
    for (int k = 0; k < 6; k++) begin
      push(200 + k, 0, k == 5);
      if (k == 1) chk("mid_rst_no_stale", int'(out_valid), 0);
    end
    chk("mid_rst_new_ov", int'(out_valid), 1);
    chk("mid_rst_new_op1", int'($signed(op[0])), 200);
    chk("mid_rst_new_op7", int'($signed(op[6])), 203);
    tick();
    for (int k = 0; k < 6; k++) push(k, k == 1 ? -4096 : k == 3 ? 100 : 7, k == 5);
    chk("neg_op2", int'($signed(op[1])), 7);
`ifdef FEEDER_CONJ_NEG_EN
    chk("neg_op4", int'($signed(op[3])), 4095);
    chk("neg_op8", int'($signed(op[7])), -100);
    chk("neg_op12", int'($signed(op[11])), -7);
`else
    chk("neg_op4", int'($signed(op[3])), -4096);
    chk("neg_op8", int'($signed(op[7])), 100);
    chk("neg_op12", int'($signed(op[11])), 7);
`endif
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
